// File: rtl/othello_pkg.sv
// Shared definitions for the Othello move engine: cell codes, direction
// encoding with its row/column step table, FSM states and colour helpers.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_BLOCK = 2'b11;

    // Ray directions, scanned in this order.
    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_e;

    localparam logic [2:0] DIR_LAST = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ORIG_RD,
        ST_ORIG_WAIT,
        ST_ORIG_EVAL,
        ST_STEP,
        ST_WAIT,
        ST_EVAL,
        ST_FLIP,
        ST_NEXT_DIR,
        ST_PLACE,
        ST_DONE
    } state_e;

    // Row step per direction (north is towards row 0).
    function automatic logic signed [1:0] dir_dr(input logic [2:0] dir);
        case (dir)
            DIR_N, DIR_NE, DIR_NW: dir_dr = -2'sd1;
            DIR_SE, DIR_S, DIR_SW: dir_dr = 2'sd1;
            default:               dir_dr = 2'sd0;
        endcase
    endfunction

    // Column step per direction (east is towards higher columns).
    function automatic logic signed [1:0] dir_dc(input logic [2:0] dir);
        case (dir)
            DIR_NE, DIR_E, DIR_SE: dir_dc = 2'sd1;
            DIR_SW, DIR_W, DIR_NW: dir_dc = -2'sd1;
            default:               dir_dc = 2'sd0;
        endcase
    endfunction

    // Board code of a player's own pieces (0 = black, 1 = white).
    function automatic logic [1:0] own_code(input logic player);
        own_code = player ? CELL_WHITE : CELL_BLACK;
    endfunction

endpackage

// File: rtl/othello_move_if.sv
// Request/result handshake plus board RAM port of the move engine.
// The master side is the environment: it issues moves and models the RAM
// (mem_rdata returns the addressed cell one cycle after mem_addr).
interface othello_move_if #(
    parameter int BOARD_DIM = 8
);
    localparam int COORD_W = $clog2(BOARD_DIM);
    localparam int ADDR_W  = $clog2(BOARD_DIM * BOARD_DIM);

    logic               start;
    logic               player;
    logic [COORD_W-1:0] move_row;
    logic [COORD_W-1:0] move_col;
    logic               check_only;
    logic               busy;
    logic               done;
    logic               valid;
    logic [ADDR_W-1:0]  flip_count;
    logic [ADDR_W-1:0]  mem_addr;
    logic [1:0]         mem_wdata;
    logic               mem_wren;
    logic [1:0]         mem_rdata;

    modport master (
        output start, player, move_row, move_col, check_only, mem_rdata,
        input  busy, done, valid, flip_count, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  start, player, move_row, move_col, check_only, mem_rdata,
        output busy, done, valid, flip_count, mem_addr, mem_wdata, mem_wren
    );

endinterface

// File: rtl/othello_ray_walker.sv
// Ray coordinate tracker. Holds the current (row, col) of a ray explicitly,
// so stepping can never wrap from one board row into the next. off_board
// reports whether the next advance in the current direction would leave
// the board.
module othello_ray_walker
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = $clog2(BOARD_DIM),
    parameter int ADDR_W    = $clog2(BOARD_DIM * BOARD_DIM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] origin_row,
    input  logic [COORD_W-1:0] origin_col,
    input  logic [2:0]         dir,
    input  logic               load_origin,  // rewind to the target square
    input  logic               load_first,   // jump to the cell next to the target
    input  logic               advance,      // one step along dir
    output logic [COORD_W-1:0] cur_row,
    output logic [COORD_W-1:0] cur_col,
    output logic [ADDR_W-1:0]  addr,
    output logic               off_board
);
    // Two extra bits: one for sign, one so BOARD_DIM-1 stays positive.
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] MAX_C = SW'(BOARD_DIM - 1);

    logic [COORD_W-1:0]   cur_row_q, cur_row_d;
    logic [COORD_W-1:0]   cur_col_q, cur_col_d;
    logic signed [1:0]    dr, dc;
    logic signed [SW-1:0] dr_ext, dc_ext;
    logic signed [SW-1:0] nxt_row, nxt_col;
    logic signed [SW-1:0] first_row, first_col;

    // Next-cell arithmetic, bound test and coordinate update selection.
    always_comb begin
        dr        = dir_dr(dir);
        dc        = dir_dc(dir);
        dr_ext    = {{COORD_W{dr[1]}}, dr};
        dc_ext    = {{COORD_W{dc[1]}}, dc};
        nxt_row   = $signed({2'b00, cur_row_q}) + dr_ext;
        nxt_col   = $signed({2'b00, cur_col_q}) + dc_ext;
        first_row = $signed({2'b00, origin_row}) + dr_ext;
        first_col = $signed({2'b00, origin_col}) + dc_ext;
        off_board = (nxt_row < 0) || (nxt_row > MAX_C) ||
                    (nxt_col < 0) || (nxt_col > MAX_C);

        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        if (load_origin) begin
            cur_row_d = origin_row;
            cur_col_d = origin_col;
        end else if (load_first) begin
            cur_row_d = first_row[COORD_W-1:0];
            cur_col_d = first_col[COORD_W-1:0];
        end else if (advance) begin
            cur_row_d = nxt_row[COORD_W-1:0];
            cur_col_d = nxt_col[COORD_W-1:0];
        end
    end

    // Coordinate registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
        end else begin
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
        end
    end

    assign cur_row = cur_row_q;
    assign cur_col = cur_col_q;
    assign addr    = ADDR_W'(cur_row_q) * ADDR_W'(BOARD_DIM) + ADDR_W'(cur_col_q);

endmodule

// File: rtl/othello_move_engine.sv
// Othello move engine: validates a move on an NxN board by scanning all
// eight rays from the target square and, unless check_only is set, flips
// every captured run and places the new piece through a single-port RAM.
module othello_move_engine
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = $clog2(BOARD_DIM),
    parameter int ADDR_W    = $clog2(BOARD_DIM * BOARD_DIM)
) (
    input  logic           clock,
    input  logic           reset,
    othello_move_if.slave  bus
);
    state_e             state_q, state_d;
    logic               player_q, player_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic               check_q, check_d;
    logic [2:0]         dir_q, dir_d;
    logic [ADDR_W-1:0]  run_q, run_d;
    logic [ADDR_W-1:0]  flips_q, flips_d;
    logic               valid_q, valid_d;

    logic               load_origin, load_first, advance;
    logic [COORD_W-1:0] walk_row, walk_col;
    logic [ADDR_W-1:0]  walk_addr;
    logic               walk_off;
    logic [1:0]         own_c, opp_c;
    logic               row_oob, col_oob;
    logic               walk_pos_unused;

    othello_ray_walker #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W),
        .ADDR_W    (ADDR_W)
    ) u_walker (
        .clock       (clock),
        .reset       (reset),
        .origin_row  (row_q),
        .origin_col  (col_q),
        .dir         (dir_q),
        .load_origin (load_origin),
        .load_first  (load_first),
        .advance     (advance),
        .cur_row     (walk_row),
        .cur_col     (walk_col),
        .addr        (walk_addr),
        .off_board   (walk_off)
    );

    // The walker's address already encodes its position.
    assign walk_pos_unused = ^{walk_row, walk_col};

    assign own_c   = own_code(player_q);
    assign opp_c   = own_code(~player_q);
    assign row_oob = ({1'b0, row_q} >= (COORD_W + 1)'(BOARD_DIM));
    assign col_oob = ({1'b0, col_q} >= (COORD_W + 1)'(BOARD_DIM));

    // Move sequencing: next state, datapath updates and RAM port drive.
    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        row_d         = row_q;
        col_d         = col_q;
        check_d       = check_q;
        dir_d         = dir_q;
        run_d         = run_q;
        flips_d       = flips_q;
        valid_d       = valid_q;
        load_origin   = 1'b0;
        load_first    = 1'b0;
        advance       = 1'b0;
        bus.mem_addr  = walk_addr;
        bus.mem_wdata = CELL_EMPTY;
        bus.mem_wren  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    player_d = bus.player;
                    row_d    = bus.move_row;
                    col_d    = bus.move_col;
                    check_d  = bus.check_only;
                    valid_d  = 1'b0;
                    flips_d  = '0;
                    run_d    = '0;
                    dir_d    = '0;
                    state_d  = ST_ORIG_RD;
                end
            end
            ST_ORIG_RD: begin
                if (row_oob || col_oob) begin
                    state_d = ST_DONE;
                end else begin
                    load_origin = 1'b1;
                    state_d     = ST_ORIG_WAIT;
                end
            end
            ST_ORIG_WAIT: begin
                state_d = ST_ORIG_EVAL;
            end
            ST_ORIG_EVAL: begin
                if (bus.mem_rdata != CELL_EMPTY) begin
                    state_d = ST_DONE;
                end else begin
                    dir_d   = '0;
                    run_d   = '0;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (walk_off) begin
                    state_d = ST_NEXT_DIR;
                end else begin
                    advance = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (bus.mem_rdata == opp_c) begin
                    run_d   = run_q + 1'b1;
                    state_d = ST_STEP;
                end else if (bus.mem_rdata == own_c && run_q != '0) begin
                    flips_d = flips_q + run_q;
                    if (check_q) begin
                        state_d = ST_NEXT_DIR;
                    end else begin
                        load_first = 1'b1;
                        state_d    = ST_FLIP;
                    end
                end else begin
                    state_d = ST_NEXT_DIR;
                end
            end
            ST_FLIP: begin
                // run_q counts the captured cells still to be written.
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = own_c;
                advance       = 1'b1;
                run_d         = run_q - 1'b1;
                if (run_q == ADDR_W'(1)) begin
                    state_d = ST_NEXT_DIR;
                end
            end
            ST_NEXT_DIR: begin
                run_d       = '0;
                load_origin = 1'b1;
                if (dir_q != DIR_LAST) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = ST_STEP;
                end else if (flips_q != '0 && !check_q) begin
                    state_d = ST_PLACE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_PLACE: begin
                // Walker was rewound to the target in NEXT_DIR.
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = own_c;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Legality is visible in the same cycle as the done pulse.
        if (state_d == ST_DONE) begin
            valid_d = (flips_d != '0);
        end
    end

    // State and datapath registers; reset aborts any move in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            player_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            check_q  <= 1'b0;
            dir_q    <= '0;
            run_q    <= '0;
            flips_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            row_q    <= row_d;
            col_q    <= col_d;
            check_q  <= check_d;
            dir_q    <= dir_d;
            run_q    <= run_d;
            flips_q  <= flips_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.valid      = valid_q;
    assign bus.flip_count = flips_q;

endmodule

// File: tb/tb_othello_move_engine.sv
// Scoreboard bench for othello_move_engine: an 8x8 and a 6x6 instance, each
// with a RAM model. Drivers queue expected writes and results; monitors pop
// and compare whenever a DUT writes or signals done.
module tb_othello_move_engine;
    import othello_pkg::*;

    typedef struct {
        int v;
        int fc;
        int nwr;
        int maxlat;
    } res_t;

    typedef struct {
        int a;
        int d;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    othello_move_if #(.BOARD_DIM(8)) bus8();
    othello_move_if #(.BOARD_DIM(6)) bus6();

    othello_move_engine #(.BOARD_DIM(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));
    othello_move_engine #(.BOARD_DIM(6)) dut6 (.clock(clock), .reset(reset), .bus(bus6));

    logic [1:0] mem8 [64];
    logic [1:0] mem6 [36];

    res_t exp8[$];
    res_t exp6[$];
    wr_t  wr8[$];
    wr_t  wr6[$];
    int   nwr8, lat8, nwr6, lat6;

    localparam int BOUND8_BASE = 4 + 8 * (3 * 7 + 1) + 2;
    localparam int BOUND6_BASE = 4 + 8 * (3 * 5 + 1) + 2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Synchronous-read RAM models: data appears one cycle after the address.
    initial begin
        bus8.mem_rdata = 2'b00;
        forever begin
            @(posedge clock);
            if (bus8.mem_wren) mem8[bus8.mem_addr] <= bus8.mem_wdata;
            bus8.mem_rdata <= mem8[bus8.mem_addr];
        end
    end

    initial begin
        bus6.mem_rdata = 2'b00;
        forever begin
            @(posedge clock);
            if (bus6.mem_wren) mem6[bus6.mem_addr] <= bus6.mem_wdata;
            bus6.mem_rdata <= mem6[bus6.mem_addr];
        end
    end

    // Monitor for the 8x8 instance.
    initial begin
        wr_t  w;
        res_t r;
        nwr8 = 0;
        lat8 = 0;
        forever begin
            @(negedge clock);
            if (bus8.busy) lat8++;
            if (bus8.mem_wren) begin
                nwr8++;
                if (wr8.size() == 0) begin
                    chk("wr8 unexpected addr", int'(bus8.mem_addr), -1);
                end else begin
                    w = wr8.pop_front();
                    chk("wr8 addr", int'(bus8.mem_addr), w.a);
                    chk("wr8 data", int'(bus8.mem_wdata), w.d);
                end
            end
            if (bus8.done) begin
                if (exp8.size() == 0) begin
                    chk("done8 unexpected flips", int'(bus8.flip_count), -1);
                end else begin
                    r = exp8.pop_front();
                    chk("done8 valid", int'(bus8.valid), r.v);
                    chk("done8 flip_count", int'(bus8.flip_count), r.fc);
                    chk("done8 write cycles", nwr8, r.nwr);
                    chk("done8 latency within bound", int'(lat8 + 1 <= r.maxlat), 1);
                    chk("done8 busy low", int'(bus8.busy), 0);
                end
                nwr8 = 0;
                lat8 = 0;
            end
        end
    end

    // Monitor for the 6x6 instance.
    initial begin
        wr_t  w;
        res_t r;
        nwr6 = 0;
        lat6 = 0;
        forever begin
            @(negedge clock);
            if (bus6.busy) lat6++;
            if (bus6.mem_wren) begin
                nwr6++;
                if (wr6.size() == 0) begin
                    chk("wr6 unexpected addr", int'(bus6.mem_addr), -1);
                end else begin
                    w = wr6.pop_front();
                    chk("wr6 addr", int'(bus6.mem_addr), w.a);
                    chk("wr6 data", int'(bus6.mem_wdata), w.d);
                end
            end
            if (bus6.done) begin
                if (exp6.size() == 0) begin
                    chk("done6 unexpected flips", int'(bus6.flip_count), -1);
                end else begin
                    r = exp6.pop_front();
                    chk("done6 valid", int'(bus6.valid), r.v);
                    chk("done6 flip_count", int'(bus6.flip_count), r.fc);
                    chk("done6 write cycles", nwr6, r.nwr);
                    chk("done6 latency within bound", int'(lat6 + 1 <= r.maxlat), 1);
                end
                nwr6 = 0;
                lat6 = 0;
            end
        end
    end

    task automatic push_wr8(input int a, input int d);
        wr_t w;
        w.a = a; w.d = d;
        wr8.push_back(w);
    endtask

    task automatic push_wr6(input int a, input int d);
        wr_t w;
        w.a = a; w.d = d;
        wr6.push_back(w);
    endtask

    task automatic push_res8(input int v, input int fc, input int nwr, input int maxlat);
        res_t r;
        r.v = v; r.fc = fc; r.nwr = nwr; r.maxlat = maxlat;
        exp8.push_back(r);
    endtask

    task automatic push_res6(input int v, input int fc, input int nwr, input int maxlat);
        res_t r;
        r.v = v; r.fc = fc; r.nwr = nwr; r.maxlat = maxlat;
        exp6.push_back(r);
    endtask

    task automatic go8(input logic p, input int r, input int c, input logic co);
        @(negedge clock); #1;
        bus8.player     = p;
        bus8.move_row   = 3'(r);
        bus8.move_col   = 3'(c);
        bus8.check_only = co;
        bus8.start      = 1'b1;
        @(negedge clock); #1;
        bus8.start      = 1'b0;
    endtask

    task automatic go6(input logic p, input int r, input int c, input logic co);
        @(negedge clock); #1;
        bus6.player     = p;
        bus6.move_row   = 3'(r);
        bus6.move_col   = 3'(c);
        bus6.check_only = co;
        bus6.start      = 1'b1;
        @(negedge clock); #1;
        bus6.start      = 1'b0;
    endtask

    task automatic wait8(input int limit);
        int n = 0;
        while (bus8.done !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (bus8.done !== 1'b1) chk("timeout8 done", int'(bus8.done), 1);
    endtask

    task automatic wait6(input int limit);
        int n = 0;
        while (bus6.done !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (bus6.done !== 1'b1) chk("timeout6 done", int'(bus6.done), 1);
    endtask

    task automatic clear8();
        for (int i = 0; i < 64; i++) mem8[i] = CELL_EMPTY;
    endtask

    task automatic set8(input int r, input int c, input logic [1:0] v);
        mem8[r * 8 + c] = v;
    endtask

    task automatic init8();
        clear8();
        set8(3, 3, CELL_WHITE); set8(3, 4, CELL_BLACK);
        set8(4, 3, CELL_BLACK); set8(4, 4, CELL_WHITE);
    endtask

    task automatic multi8();
        clear8();
        set8(0, 4, CELL_BLACK); set8(4, 0, CELL_BLACK); set8(4, 4, CELL_BLACK);
        for (int i = 1; i <= 3; i++) begin
            set8(0, i, CELL_WHITE);
            set8(i, 0, CELL_WHITE);
            set8(i, i, CELL_WHITE);
        end
    endtask

    task automatic init6();
        for (int i = 0; i < 36; i++) mem6[i] = CELL_EMPTY;
        mem6[2 * 6 + 2] = CELL_WHITE; mem6[2 * 6 + 3] = CELL_BLACK;
        mem6[3 * 6 + 2] = CELL_BLACK; mem6[3 * 6 + 3] = CELL_WHITE;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bus8.start = 1'b0; bus8.player = 1'b0; bus8.move_row = '0;
        bus8.move_col = '0; bus8.check_only = 1'b0;
        bus6.start = 1'b0; bus6.player = 1'b0; bus6.move_row = '0;
        bus6.move_col = '0; bus6.check_only = 1'b0;
        clear8();
        init6();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset busy", int'(bus8.busy), 0);
        chk("reset done", int'(bus8.done), 0);
        chk("reset valid", int'(bus8.valid), 0);
        chk("reset flip_count", int'(bus8.flip_count), 0);
        chk("reset mem_wren", int'(bus8.mem_wren), 0);
        chk("reset mem_addr", int'(bus8.mem_addr), 0);
        chk("reset mem_wdata", int'(bus8.mem_wdata), 0);
        #1 reset = 1'b0;

        // Opening board, black (2,3) commit: flip (3,3) then place.
        init8();
        push_wr8(27, 1); push_wr8(19, 1);
        push_res8(1, 1, 2, BOUND8_BASE + 1);
        go8(1'b0, 2, 3, 1'b0);
        wait8(400);

        // Same move validate-only: result without touching the board.
        init8();
        push_res8(1, 1, 0, BOUND8_BASE + 1);
        go8(1'b0, 2, 3, 1'b1);
        wait8(400);
        chk("check_only cell 19", int'(mem8[19]), 0);
        chk("check_only cell 27", int'(mem8[27]), 2);

        // White (2,4): captures (3,4) southwards.
        init8();
        push_wr8(28, 2); push_wr8(20, 2);
        push_res8(1, 1, 2, BOUND8_BASE + 1);
        go8(1'b1, 2, 4, 1'b0);
        wait8(400);

        // Occupied target resolves quickly and illegally.
        init8();
        push_res8(0, 0, 0, 5);
        go8(1'b0, 3, 3, 1'b0);
        wait8(400);

        // Corner with no neighbours: full scan, nothing captured.
        push_res8(0, 0, 0, BOUND8_BASE);
        go8(1'b0, 0, 0, 1'b0);
        wait8(400);

        // Row-wrap guard: (0,7)=W, (0,6)=B must not be seen from (1,0).
        clear8();
        set8(0, 7, CELL_WHITE); set8(0, 6, CELL_BLACK);
        push_res8(0, 0, 0, BOUND8_BASE);
        go8(1'b0, 1, 0, 1'b0);
        wait8(400);

        // Three captured rays from the corner: E, SE, S then place.
        multi8();
        push_wr8(1, 1); push_wr8(2, 1); push_wr8(3, 1);
        push_wr8(9, 1); push_wr8(18, 1); push_wr8(27, 1);
        push_wr8(8, 1); push_wr8(16, 1); push_wr8(24, 1);
        push_wr8(0, 1);
        push_res8(1, 9, 10, BOUND8_BASE + 9);
        go8(1'b0, 0, 0, 1'b0);
        wait8(400);
        chk("multi cell 27 flipped", int'(mem8[27]), 1);

        // Abort in the second FLIP cycle of the same move.
        multi8();
        push_wr8(1, 1);
        go8(1'b0, 0, 0, 1'b0);
        n = 0;
        while (bus8.mem_wren !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("abort saw first flip", int'(bus8.mem_wren), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("abort busy", int'(bus8.busy), 0);
        chk("abort done", int'(bus8.done), 0);
        chk("abort mem_wren", int'(bus8.mem_wren), 0);
        @(negedge clock);
        nwr8 = 0;
        lat8 = 0;
        #1 reset = 1'b0;
        chk("abort cell 1 kept", int'(mem8[1]), 1);
        chk("abort cell 2 untouched", int'(mem8[2]), 2);

        // Restart on the partially flipped board: E ray now blocked.
        push_wr8(9, 1); push_wr8(18, 1); push_wr8(27, 1);
        push_wr8(8, 1); push_wr8(16, 1); push_wr8(24, 1);
        push_wr8(0, 1);
        push_res8(1, 6, 7, BOUND8_BASE + 6);
        go8(1'b0, 0, 0, 1'b0);
        wait8(400);

        // 6x6 opening board, black (1,2): flip (2,2) then place.
        init6();
        push_wr6(14, 1); push_wr6(8, 1);
        push_res6(1, 1, 2, BOUND6_BASE + 1);
        go6(1'b0, 1, 2, 1'b0);
        wait6(400);

        // 6x6 target row 6 is off the board.
        push_res6(0, 0, 0, 3);
        go6(1'b0, 6, 0, 1'b0);
        wait6(400);

        repeat (3) @(negedge clock);
        chk("pending writes 8", wr8.size(), 0);
        chk("pending results 8", exp8.size(), 0);
        chk("pending writes 6", wr6.size(), 0);
        chk("pending results 6", exp6.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/othello_move_engine.md
Name: othello_move_engine

Overview:
Parametrised move engine for an NxN Othello board. It fuses the validate and flip steps into one block that drives a single-port board RAM directly. Given a player and a target square, it scans all eight directions and reports legality and flip count. In commit mode it also writes every captured cell and the placed piece. Unlike the fixed 8x8 step-address validator/flipper pair, it tracks row and column explicitly, so rays never wrap across row edges.

Parameters:
- BOARD_DIM, 8, board side length; even, 4..16.
- COORD_W, $clog2(BOARD_DIM), row/col width.
- ADDR_W, $clog2(BOARD_DIM*BOARD_DIM), RAM address width; addr = row*BOARD_DIM + col.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- player  in  1  0 = black (cell 2'b01), 1 = white (cell 2'b10); latched on start.
- move_row  in  COORD_W  target row; latched on start.
- move_col  in  COORD_W  target column; latched on start.
- check_only  in  1  1 = validate only (no writes); latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the move is resolved.
- valid  out  1  legality result; held until the next start.
- flip_count  out  ADDR_W  total cells captured; held until the next start.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  2  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_rdata  in  2  RAM read data; valid exactly 1 cycle after mem_addr.

Behaviour:
- Reset (async): state IDLE. busy, done, valid, mem_wren = 0. flip_count, mem_addr, mem_wdata = 0. Reset mid-move aborts immediately. Cells already written stay written; the board is not rolled back.
- Cell codes: 00 empty, 01 black, 10 white, 11 treated as blocking (ends a ray with no capture).
- IDLE: on start, latch inputs and clear valid/flip_count, then go to ORIG_RD. start while busy is ignored.
- ORIG_RD: if move_row or move_col is ≥ BOARD_DIM, go to DONE with valid=0. Otherwise issue the target address, then ORIG_WAIT, then ORIG_EVAL.
- ORIG_EVAL: if the cell is non-empty, go to DONE with valid=0 and no writes. Otherwise set dir=0 and go to STEP.
- Directions 0..7 = N, NE, E, SE, S, SW, W, NW, evaluated in that order.
- STEP: advance the ray coordinate by (dr,dc). If it leaves [0,BOARD_DIM-1] in either axis, the ray fails. Otherwise issue a read, then WAIT, then EVAL. Each cell examined costs 3 cycles.
- EVAL outcomes:
  - opponent: run_len++, back to STEP.
  - own with run_len ≥ 1: ray captures run_len cells; flip_count += run_len.
  - own with run_len = 0, empty, or 11: ray fails.
- Ray captures with check_only=0: go to FLIP. FLIP writes own code to the run_len cells, walking from the cell adjacent to the origin outward, one write per cycle (mem_wren=1 on each). Then NEXT_DIR.
- Ray captures with check_only=1, or ray fails: go to NEXT_DIR.
- NEXT_DIR: clear run_len. If dir < 7, increment dir and go to STEP.
- After dir 7: if flip_count > 0 and check_only=0, go to PLACE, which writes own code at the target (1 cycle), then DONE. Otherwise go straight to DONE.
- DONE: done=1 for one cycle; valid = (flip_count > 0); busy drops the same cycle; return to IDLE.
- mem_wren is high only in FLIP/PLACE cycles and never in check_only moves.
- Latency bound: done ≤ 4 + 8·(3·(BOARD_DIM-1)+1) + flip_count + 2 cycles after start.
- flip_count never saturates: the maximum legal capture is below BOARD_DIM².

Decomposition:
- Package othello_pkg holds:
  - cell code constants (CELL_EMPTY, CELL_BLACK, CELL_WHITE);
  - direction encoding and the signed dr/dc lookup table;
  - the state enum;
  - a function own_code(player).
- One natural sub-module: othello_ray_walker, which holds the coordinate/step/bound logic. It takes origin, dir and advance, and outputs cur_row, cur_col, addr and off_board. The FSM stays in the top.

Test Plan:
- Initial 8x8 board, (3,3)=W, (3,4)=B, (4,3)=B, (4,4)=W; black, target (2,3), commit -> valid=1, flip_count=1; writes addr 27:=01 then addr 19:=01, exactly 2 wren cycles.
- Same board, check_only=1, target (2,3) -> valid=1, flip_count=1, zero mem_wren cycles, board unchanged.
- Same board, target (3,3) (occupied) -> done within 5 cycles, valid=0, no writes. Target (0,0) -> full scan, valid=0, flip_count=0.
- Row-wrap guard: empty board except addr 7 (0,7)=W and addr 6 (0,6)=B; black at (1,0), addr 8 -> valid=0, no writes.
- Multi-direction: B at (0,0),(0,4),(4,0); W at (0,1..3),(1,1),(2,2),(3,3),(1..3,0); B at (4,4) -> black at... Use target (0,0) empty, B at (0,4),(4,0),(4,4) and W rays between -> flip_count=9; 10 writes; done within the latency bound.
- Reset asserted on the 2nd FLIP cycle -> busy, done, mem_wren = 0 the same cycle. A subsequent start completes normally. Repeat one scenario with BOARD_DIM=6.
